// File: rtl/matrix_result_buffer_pkg.sv
// Shared types and width helpers for matrix_result_buffer and its neighbours.
package matrix_result_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } mrb_state_t;

  // Index width for a count of n, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Product word width used by the multiplier, this buffer and their benches.
  function automatic int result_w(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/mrb_rc_counter.sv
// Wrapping row/column index counter for a row-major M x P walk, with last-element detect.
module mrb_rc_counter
  import matrix_result_buffer_pkg::*;
#(
  parameter int M = 2,
  parameter int P = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       adv,
  output logic [clog2_min1(M)-1:0]   row,
  output logic [clog2_min1(P)-1:0]   col,
  output logic                       last
);

  localparam int RW = clog2_min1(M);
  localparam int CW = clog2_min1(P);

  logic row_end;
  logic col_end;

  assign row_end = (row == RW'(M - 1));
  assign col_end = (col == CW'(P - 1));
  assign last    = row_end && col_end;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_result_buffer.sv
// Captures one row-major M x P result matrix, then drains it over valid/ready with row/col/last tags.
// Optional min/max statistics are built when MRB_STATS_EN is defined.
module matrix_result_buffer
  import matrix_result_buffer_pkg::*;
#(
  parameter int M          = 2,
  parameter int P          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic [result_w(DATA_WIDTH)-1:0]   c_in,
  input  logic                              c_valid,
  output logic [result_w(DATA_WIDTH)-1:0]   out_data,
  output logic [clog2_min1(M)-1:0]          out_row,
  output logic [clog2_min1(P)-1:0]          out_col,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              full,
  output logic                              overflow,
  output logic                              drain_done,
  output logic [result_w(DATA_WIDTH)-1:0]   stat_max,
  output logic [result_w(DATA_WIDTH)-1:0]   stat_min
);

  localparam int RESULT_W = result_w(DATA_WIDTH);
  localparam int DEPTH    = M * P;
  localparam int PW       = clog2_min1(DEPTH);

  mrb_state_t state, state_nxt;

  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                capture;
  logic                handshake;
  logic                drop;
  logic                cnt_last;
  logic                draining;
  logic [RESULT_W-1:0] mem [DEPTH];

  assign draining = (state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    handshake = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_CAPTURE: begin
          if (c_valid) begin
            capture   = 1'b1;
            state_nxt = (wr_ptr == PW'(DEPTH - 1)) ? ST_DRAIN : ST_CAPTURE;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            handshake = 1'b1;
            if (cnt_last) state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Words arriving while the buffer is draining have nowhere to go.
  assign drop = c_valid && draining && !clear;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      if (capture)   wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (handshake) rd_ptr <= cnt_last ? '0 : rd_ptr + 1'b1;
      if (drop)      overflow <= 1'b1;
      drain_done <= handshake && cnt_last;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and state alone define validity.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= c_in;
  end

  mrb_rc_counter #(.M(M), .P(P)) u_rc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .adv  (handshake),
    .row  (out_row),
    .col  (out_col),
    .last (cnt_last)
  );

  assign out_valid = draining;
  assign full      = draining;
  assign out_last  = draining && cnt_last;
  assign out_data  = draining ? mem[rd_ptr] : '0;

`ifdef MRB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stat_max <= '0;
      stat_min <= '0;
    end else if (capture) begin
      if (state == ST_IDLE) begin
        stat_max <= c_in;
        stat_min <= c_in;
      end else begin
        if ($signed(c_in) > $signed(stat_max)) stat_max <= c_in;
        if ($signed(c_in) < $signed(stat_min)) stat_min <= c_in;
      end
    end
  end
`else
  assign stat_max = '0;
  assign stat_min = '0;
`endif

endmodule

// File: tb/tb_matrix_result_buffer.sv
// Self-checking bench for matrix_result_buffer (M=2, P=4, DATA_WIDTH=8).
module tb_matrix_result_buffer;

  typedef logic [15:0] mat_t [8];

  typedef struct {
    mat_t        mat;
    int          gap;
    int          mode;
    logic [15:0] exp_max;
    logic [15:0] exp_min;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, clear, c_valid, out_ready;
  logic [15:0] c_in;
  logic [15:0] out_data, stat_max, stat_min;
  logic [0:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last, out_valid, full, overflow, drain_done;

  int n_cmp = 0;
  int n_err = 0;

  matrix_result_buffer #(.M(2), .P(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .c_in(c_in), .c_valid(c_valid),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .full(full), .overflow(overflow),
    .drain_done(drain_done), .stat_max(stat_max), .stat_min(stat_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: signed extremes of the whole matrix, zero when the stats feature is absent.
  function automatic void model_stats(input mat_t m, output logic [15:0] mx, output logic [15:0] mn);
    mx = m[0];
    mn = m[0];
    for (int i = 1; i < 8; i++) begin
      if ($signed(m[i]) > $signed(mx)) mx = m[i];
      if ($signed(m[i]) < $signed(mn)) mn = m[i];
    end
`ifndef MRB_STATS_EN
    mx = '0;
    mn = '0;
`endif
  endfunction

  task automatic check_stats(input logic [15:0] mx, input logic [15:0] mn);
`ifndef MRB_STATS_EN
    mx = '0;
    mn = '0;
`endif
    check("stat_max", stat_max, mx);
    check("stat_min", stat_min, mn);
  endtask

  // Sends the first n words with 0..maxgap idle cycles before each; out_valid must stay low until the end.
  task automatic capture(input mat_t m, input int maxgap, input int n);
    for (int i = 0; i < n; i++) begin
      int g = $urandom_range(maxgap, 0);
      for (int k = 0; k < g; k++) begin
        check("early_valid_gap", out_valid, 0);
        step();
      end
      check("early_valid", out_valid, 0);
      c_valid = 1'b1;
      c_in    = m[i];
      step();
      c_valid = 1'b0;
    end
    if (n == 8) begin
      check("valid_after_capture", out_valid, 1);
      check("full_after_capture", full, 1);
    end
  endtask

  // mode 0: always ready, 1: ready 1,0,0,1 repeating, 2: random ready.
  task automatic drain(input mat_t m, input int mode, input bit poke_last);
    bit          pat [4];
    int          idx = 0;
    int          cyc = 0;
    bit          held = 1'b0;
    logic [15:0] h_data;
    logic [2:0]  h_tag;
    bit          rdy;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    while (idx < 8 && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(1, 0));
      out_ready = rdy;
      if (held && out_valid) begin
        check("hold_data", out_data, h_data);
        check("hold_tag", {out_row, out_col}, h_tag);
      end
      held = 1'b0;
      if (out_valid && rdy) begin
        check("drain_data", out_data, m[idx]);
        check("drain_row", out_row, idx / 4);
        check("drain_col", out_col, idx % 4);
        check("drain_last", out_last, idx == 7);
        if (poke_last && idx == 7) begin
          c_valid = 1'b1;
          c_in    = 16'h0055;
        end
        idx++;
      end else if (out_valid) begin
        held   = 1'b1;
        h_data = out_data;
        h_tag  = {out_row, out_col};
      end
      step();
      c_valid = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", idx, 8);
    check("valid_dropped", out_valid, 0);
    check("full_dropped", full, 0);
    check("drain_done_pulse", drain_done, 1);
    step();
    check("drain_done_single", drain_done, 0);
  endtask

  task automatic check_all_zero();
    check("rst_out_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_row_col", {out_row, out_col}, 0);
    check("rst_stat_max", stat_max, 0);
    check("rst_stat_min", stat_min, 0);
  endtask

  vec_t        vecs [4];
  mat_t        basic, fresh, rm;
  logic [15:0] emx, emn;

  initial begin
    basic = '{16'd3, 16'd9, 16'd2, 16'd1, 16'd6, 16'd21, 16'd2, 16'd7};
    fresh = '{16'd40, 16'hFFF0, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16};
    vecs[0] = '{mat: basic, gap: 0, mode: 0, exp_max: 16'd21, exp_min: 16'd1};
    vecs[1] = '{mat: basic, gap: 0, mode: 1, exp_max: 16'd21, exp_min: 16'd1};
    vecs[2] = '{mat: basic, gap: 3, mode: 0, exp_max: 16'd21, exp_min: 16'd1};
    vecs[3] = '{mat: '{16'hFFFF, 16'hFED4, 16'd5, 16'd0, 16'h7FFF, 16'h8000, 16'd8, 16'd8},
                gap: 1, mode: 2, exp_max: 16'h7FFF, exp_min: 16'h8000};

    rst = 1'b1; clear = 1'b0; c_valid = 1'b0; c_in = '0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check_all_zero();

    for (int v = 0; v < 4; v++) begin
      capture(vecs[v].mat, vecs[v].gap, 8);
      drain(vecs[v].mat, vecs[v].mode, 1'b0);
      check_stats(vecs[v].exp_max, vecs[v].exp_min);
      check("no_overflow", overflow, 0);
    end

    // Overflow: two words land during DRAIN while the consumer stalls.
    capture(basic, 0, 8);
    c_valid = 1'b1; c_in = 16'd100;
    step();
    c_in = 16'hFFFB;
    step();
    c_valid = 1'b0;
    check("overflow_set", overflow, 1);
    drain(basic, 0, 1'b0);
    check("overflow_sticky", overflow, 1);
    check_stats(16'd21, 16'd1);

    // clear mid-capture, with a coincident c_valid that must be dropped silently.
    capture(basic, 1, 5);
    clear = 1'b1; c_valid = 1'b1; c_in = 16'h0077;
    step();
    clear = 1'b0; c_valid = 1'b0;
    check("clear_overflow", overflow, 0);
    check("clear_full", full, 0);
    capture(fresh, 0, 8);
    drain(fresh, 0, 1'b0);
    check("clear_no_overflow", overflow, 0);
    check_stats(16'd40, 16'hFFF0);

    // Back-to-back: word coincident with final handshake is dropped; next matrix is clean.
    capture(basic, 0, 8);
    drain(basic, 0, 1'b1);
    check("b2b_overflow", overflow, 1);
    capture(fresh, 0, 8);
    drain(fresh, 2, 1'b0);

    // rst after three handshakes.
    capture(basic, 0, 8);
    out_ready = 1'b1;
    repeat (3) step();
    check("mid_drain_row_col", {out_row, out_col}, 3);
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero();
    capture(fresh, 2, 8);
    drain(fresh, 1, 1'b0);

    // Randomized matrices against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) rm[i] = 16'($urandom);
      model_stats(rm, emx, emn);
      capture(rm, $urandom_range(3, 0), 8);
      drain(rm, $urandom_range(2, 0), 1'b0);
      check("rand_stat_max", stat_max, emx);
      check("rand_stat_min", stat_min, emn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_result_buffer.md
Name: matrix_result_buffer

Overview:
- Downstream stage of simple_generic_matrix_mult. Captures the row-major c_out/c_valid result stream of one M x P product into an internal register array.
- Once the matrix is complete, drains it over a valid/ready stream tagged with row/col indices and a last flag.
- Decouples the multiplier's fixed-rate output from a back-pressuring consumer (UART formatter, DMA, host read).

Parameters:
- M, 2, rows of result C
- P, 4, columns of result C
- DATA_WIDTH, 8, multiplier element width; result word is 2*DATA_WIDTH, signed
- Derived localparams: DEPTH = M*P; PW = (DEPTH<2) ? 1 : $clog2(DEPTH); RW = (M<2) ? 1 : $clog2(M); CW = (P<2) ? 1 : $clog2(P)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous abort: discard contents, return to IDLE
- c_in  in  2*DATA_WIDTH  result word from multiplier c_out
- c_valid  in  1  c_in valid this cycle; no back-pressure to the multiplier
- out_data  out  2*DATA_WIDTH  drained result word
- out_row  out  RW  row index of out_data
- out_col  out  CW  column index of out_data
- out_last  out  1  out_data is element DEPTH-1
- out_valid  out  1  drain word available
- out_ready  in  1  consumer accepts word
- full  out  1  all DEPTH words captured, not yet fully drained
- overflow  out  1  sticky: a c_valid word was dropped
- drain_done  out  1  one-cycle pulse after the last word is accepted
- stat_max  out  2*DATA_WIDTH  signed maximum captured (optional feature)
- stat_min  out  2*DATA_WIDTH  signed minimum captured (optional feature)

Behaviour:
- Reset (rst=1 at posedge): state IDLE, wr_ptr=0, rd_ptr=0.
  - All outputs 0: out_valid, full, overflow, drain_done, out_last, out_data, out_row, out_col, stat_*.
  - Array contents undefined.
- Priority: rst > clear > normal operation. clear zeroes the pointers, overflow and stat_*, and forces IDLE. A c_valid coincident with clear is dropped without setting overflow.
- IDLE:
  - c_valid writes mem[0], wr_ptr becomes 1.
  - Next state CAPTURE, or DRAIN directly if DEPTH==1.
- CAPTURE:
  - Each c_valid writes mem[wr_ptr] and increments wr_ptr.
  - The write at wr_ptr==DEPTH-1 moves to DRAIN next cycle. out_valid and full rise one cycle after the final capture.
  - Gaps between c_valid pulses are allowed; there is no timeout.
- DRAIN:
  - out_valid=1, full=1.
  - out_data=mem[rd_ptr] (combinational read from the registered pointer).
  - out_row = rd_ptr / P and out_col = rd_ptr % P, maintained as separate wrapping counters, no divider.
  - out_last = (rd_ptr==DEPTH-1).
  - On out_valid && out_ready: rd_ptr increments, col increments; col wraps to 0 at P-1 and row increments.
  - Holding out_ready=0 keeps all out_* stable.
- DRAIN exit:
  - A handshake with out_last=1 goes to IDLE.
  - Pointers return to 0, full/out_valid drop next cycle, drain_done pulses for exactly one cycle.
- Overflow: c_valid while in DRAIN drops the word and sets overflow=1. overflow is sticky until rst or clear. Buffer contents and the drain sequence are unaffected.
- Back-to-back matrices: a c_valid in the same cycle as the final handshake is dropped and flagged as overflow. A new capture is accepted from the following cycle (IDLE).
- Data is stored verbatim: no truncation, sign extension or arithmetic on c_in.

Optional Feature:
- Macro: MRB_STATS_EN
- With the macro defined:
  - The first capture of a matrix loads stat_max = stat_min = c_in.
  - Each subsequent capture updates them with signed compare.
  - Values are stable and meaningful while full=1, and are held through IDLE until the next first capture, clear or rst.
- Without the macro: stat_max and stat_min are constant 0, the ports remain present so the interface is stable, and no compare logic is generated.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, CAPTURE, DRAIN)
  - the width-derivation helper (clog2 with a floor of 1)
  - the RESULT_W = 2*DATA_WIDTH convention, shared with the multiplier and its bench
- One natural sub-module: mrb_rc_counter, the wrapping row/column index counter with advance input and last-element detect.

Test Plan:
- Basic (M=2, P=4): capture C = [3 9 2 1; 6 21 2 7] with out_ready=1 → drained in order 3,9,2,1,6,21,2,7; (row,col) runs (0,0)..(1,3); out_last only on 7; drain_done single pulse; with MRB_STATS_EN, stat_max=21, stat_min=1.
- Back-pressure: same data, out_ready toggled 1,0,0,1 repeating → no word lost or duplicated; out_* stable while out_ready=0; 8 handshakes total.
- Gapped capture: c_valid with 0–3 idle cycles between words → out_valid rises exactly 1 cycle after the 8th capture, never earlier.
- Overflow: two extra c_valid words (values 100, -5) during DRAIN → overflow=1 and stays set; drained data unchanged; stats unchanged.
- clear mid-capture: after 5 words assert clear, then send a fresh 8-word matrix → only the fresh matrix is drained; overflow=0.
- rst mid-drain: assert rst after 3 handshakes → next cycle all outputs 0 and state IDLE; a following full capture drains correctly from row 0, col 0.
